// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter
// Brief    : Single-port frame-buffer arbiter. The VGA pixel fetch has
//            absolute priority. A CPU read/write requester uses the
//            remaining cycles, and a round-robin flag settles read/write
//            contention. RAM read data (1-cycle latency) is routed back to
//            the display or the CPU through a one-cycle owner-tag pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic [9:0]        hCounter,
    input  logic [9:0]        vCounter,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel_data,
    output logic              pixel_valid
);

    // Owner of the RAM port in a given cycle; selects where the returning
    // read data goes one cycle later.
    localparam logic [1:0] c_TAG_NONE   = 2'd0;
    localparam logic [1:0] c_TAG_DISP   = 2'd1;
    localparam logic [1:0] c_TAG_CPU_RD = 2'd2;

    localparam logic [ADDR_W-1:0] c_STRIDE  = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] c_FB_SIZE = ADDR_W'(H_ACTIVE * V_ACTIVE);

    // Registered state
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_rr_wr_first;
    logic [1:0]        r_tag;
    logic              r_rd_oob;
    logic              r_blank;
    logic [DATA_W-1:0] r_pixel_data;
    logic              r_pixel_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    // Combinational decisions
    logic              w_in_active;
    logic              w_disp_slot;
    logic              w_blank_strobe;
    logic              w_cpu_slot;
    logic              w_grant_wr;
    logic              w_grant_rd;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic [ADDR_W-1:0] w_disp_addr;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [1:0]        w_tag;
    logic              w_rr_wr_first_nxt;
    logic [DATA_W-1:0] w_pixel_data_nxt;
    logic              w_pixel_valid_nxt;
    logic [DATA_W-1:0] w_rd_data_nxt;
    logic              w_rd_valid_nxt;

    // Grants are suppressed while reset is held so every output reads 0.
    assign w_in_active    = ({22'd0, hCounter} < H_ACTIVE) && ({22'd0, vCounter} < V_ACTIVE);
    assign w_disp_slot    = ~rst & pix_en & w_in_active;
    assign w_blank_strobe = ~rst & pix_en & ~w_in_active;
    assign w_cpu_slot     = ~rst & ~w_disp_slot;

    // On contention the flag decides; a lone request is always served.
    assign w_grant_wr = w_cpu_slot & wr_req & (~rd_req | r_rr_wr_first);
    assign w_grant_rd = w_cpu_slot & rd_req & (~wr_req | ~r_rr_wr_first);

    assign w_wr_in_range = (wr_addr < c_FB_SIZE);
    assign w_rd_in_range = (rd_addr < c_FB_SIZE);
    assign w_disp_addr   = ADDR_W'(hCounter) + c_STRIDE * ADDR_W'(vCounter);

    // Drive the RAM port from the winner of this cycle; idle holds the address.
    always_comb begin
        w_mem_addr  = r_mem_addr;
        w_mem_we    = 1'b0;
        w_mem_wdata = '0;
        w_tag       = c_TAG_NONE;
        if (w_disp_slot) begin
            w_mem_addr = w_disp_addr;
            w_tag      = c_TAG_DISP;
        end else if (w_grant_wr) begin
            w_mem_addr  = wr_addr;
            w_mem_we    = w_wr_in_range;
            w_mem_wdata = wr_data;
        end else if (w_grant_rd) begin
            w_mem_addr = rd_addr;
            w_tag      = c_TAG_CPU_RD;
        end
    end

    // The type just served loses the next contention.
    always_comb begin
        w_rr_wr_first_nxt = r_rr_wr_first;
        if (w_grant_wr) begin
            w_rr_wr_first_nxt = 1'b0;
        end else if (w_grant_rd) begin
            w_rr_wr_first_nxt = 1'b1;
        end
    end

    // Steer the returning RAM data by last cycle's owner tag.
    always_comb begin
        w_pixel_data_nxt  = r_pixel_data;
        w_pixel_valid_nxt = r_pixel_valid;
        w_rd_data_nxt     = r_rd_data;
        w_rd_valid_nxt    = (r_tag == c_TAG_CPU_RD);
        if (r_tag == c_TAG_DISP) begin
            w_pixel_data_nxt  = mem_rdata;
            w_pixel_valid_nxt = 1'b1;
        end else if (r_blank) begin
            w_pixel_data_nxt  = '0;
            w_pixel_valid_nxt = 1'b0;
        end
        if (r_tag == c_TAG_CPU_RD) begin
            w_rd_data_nxt = r_rd_oob ? '0 : mem_rdata;
        end
    end

    // Grant-side state: held address, fairness flag and the tag pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr    <= '0;
            r_rr_wr_first <= 1'b1;
            r_tag         <= c_TAG_NONE;
            r_rd_oob      <= 1'b0;
            r_blank       <= 1'b0;
        end else begin
            r_mem_addr    <= w_mem_addr;
            r_rr_wr_first <= w_rr_wr_first_nxt;
            r_tag         <= w_tag;
            r_rd_oob      <= w_grant_rd & ~w_rd_in_range;
            r_blank       <= w_blank_strobe;
        end
    end

    // Return-side registers feeding the DAC path and the CPU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pixel_data  <= '0;
            r_pixel_valid <= 1'b0;
            r_rd_data     <= '0;
            r_rd_valid    <= 1'b0;
        end else begin
            r_pixel_data  <= w_pixel_data_nxt;
            r_pixel_valid <= w_pixel_valid_nxt;
            r_rd_data     <= w_rd_data_nxt;
            r_rd_valid    <= w_rd_valid_nxt;
        end
    end

    assign mem_addr    = w_mem_addr;
    assign mem_we      = w_mem_we;
    assign mem_wdata   = w_mem_wdata;
    assign wr_ack      = w_grant_wr;
    assign rd_ack      = w_grant_rd;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign pixel_data  = r_pixel_data;
    assign pixel_valid = r_pixel_valid;

endmodule
`default_nettype wire
